// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl: pointer/flag controller turning an external dual-port RAM into a synchronous FIFO
//
// Ports:
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   wr_en, wr_data             producer write request and word
//   rd_en                      consumer read request
//   rd_data, rd_valid          read word (from RAM) and its one-cycle-late qualifier
//   full, empty                occupancy flags
//   almost_full, almost_empty  threshold flags (count >= AF_LEVEL, count <= AE_LEVEL)
//   count                      words stored, 0..2^ADDR_WIDTH
//   overflow, underflow        sticky error flags, cleared only by reset
//   ram_we, ram_waddr, ram_wdata  RAM write port
//   ram_re, ram_raddr, ram_rdata  RAM read port (RAM registers ram_rdata when ram_re is high)
module sync_fifo_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6,
    parameter int AF_LEVEL   = 60,
    parameter int AE_LEVEL   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  ram_we,
    output logic                  ram_re,
    output logic [ADDR_WIDTH-1:0] ram_waddr,
    output logic [ADDR_WIDTH-1:0] ram_raddr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);
    localparam int PW = ADDR_WIDTH + 1;

    // Extra MSB is the wrap bit: equal low bits mean empty when the wrap
    // bits match and full when they differ.
    logic [PW-1:0] wptr, rptr;
    logic          wr_acc, rd_acc;

    // Flags come from registered pointers only, so a request never
    // influences its own acceptance combinationally.
    always_comb begin
        empty        = wptr == rptr;
        full         = (wptr[ADDR_WIDTH-1:0] == rptr[ADDR_WIDTH-1:0]) && (wptr[ADDR_WIDTH] != rptr[ADDR_WIDTH]);
        count        = wptr - rptr;
        almost_full  = count >= PW'(AF_LEVEL);
        almost_empty = count <= PW'(AE_LEVEL);
        wr_acc       = wr_en & ~full;
        rd_acc       = rd_en & ~empty;
        ram_we       = wr_acc;
        ram_waddr    = wptr[ADDR_WIDTH-1:0];
        ram_wdata    = wr_data;
        ram_re       = rd_acc;
        ram_raddr    = rptr[ADDR_WIDTH-1:0];
        rd_data      = ram_rdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr      <= '0;
            rptr      <= '0;
            rd_valid  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) wptr <= wptr + PW'(1);
            if (rd_acc) rptr <= rptr + PW'(1);
            rd_valid  <= rd_acc;
            overflow  <= overflow | (wr_en & full);
            underflow <= underflow | (rd_en & empty);
        end
    end
endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// tb_sync_fifo_ctrl: directed self-checking bench for sync_fifo_ctrl with a behavioural 64x32 RAM beside it
module tb_sync_fifo_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en, rd_en;
    logic [31:0] wr_data, rd_data, ram_wdata, ram_rdata;
    logic        rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
    logic        ram_we, ram_re;
    logic [6:0]  count;
    logic [5:0]  ram_waddr, ram_raddr;
    logic [31:0] mem [64];
    int          n_vec = 0;
    int          n_err = 0;

    sync_fifo_ctrl dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow), .ram_we(ram_we), .ram_re(ram_re),
        .ram_waddr(ram_waddr), .ram_raddr(ram_raddr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) mem[ram_waddr] <= ram_wdata;
        if (ram_re) ram_rdata <= mem[ram_raddr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, " empty"}, 32'(empty), 1);
        chk({tag, " full"}, 32'(full), 0);
        chk({tag, " count"}, 32'(count), 0);
        chk({tag, " rd_valid"}, 32'(rd_valid), 0);
        chk({tag, " almost_empty"}, 32'(almost_empty), 1);
        chk({tag, " almost_full"}, 32'(almost_full), 0);
        chk({tag, " overflow"}, 32'(overflow), 0);
        chk({tag, " underflow"}, 32'(underflow), 0);
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
        cyc(); cyc();
        chk_reset_state("rst_hold");
        rst_n = 1'b1;
        cyc(); cyc(); cyc();
        chk_reset_state("rst_idle");

        // single word
        wr_en = 1'b1; wr_data = 32'h0000000F;
        #1;
        chk("single ram_we", 32'(ram_we), 1);
        chk("single ram_waddr", 32'(ram_waddr), 0);
        chk("single ram_wdata", ram_wdata, 32'h0000000F);
        cyc();
        wr_en = 1'b0;
        chk("single count", 32'(count), 1);
        chk("single empty", 32'(empty), 0);
        rd_en = 1'b1;
        #1;
        chk("single ram_re", 32'(ram_re), 1);
        chk("single ram_raddr", 32'(ram_raddr), 0);
        cyc();
        rd_en = 1'b0;
        chk("single rd_valid", 32'(rd_valid), 1);
        chk("single rd_data", rd_data, 32'h0000000F);
        chk("single empty after", 32'(empty), 1);
        cyc();
        chk("single rd_valid drop", 32'(rd_valid), 0);

        // fill to full: pointers start at 1, so address 63 -> 0 wraps mid-fill
        for (int i = 0; i <= 64; i++) begin
            wr_en = 1'b1; wr_data = 32'(i);
            #1;
            if (i == 62) chk("fill waddr 63", 32'(ram_waddr), 63);
            if (i == 63) chk("fill waddr wrap", 32'(ram_waddr), 0);
            if (i == 64) begin
                chk("fill 65th ram_we", 32'(ram_we), 0);
                chk("fill ovf before", 32'(overflow), 0);
            end
            cyc();
            if (i == 3)  chk("fill ae at 4", 32'(almost_empty), 1);
            if (i == 4)  chk("fill ae at 5", 32'(almost_empty), 0);
            if (i == 58) chk("fill af at 59", 32'(almost_full), 0);
            if (i == 59) chk("fill af at 60", 32'(almost_full), 1);
            if (i == 62) chk("fill full at 63", 32'(full), 0);
            if (i == 63) chk("fill full at 64", 32'(full), 1);
        end
        wr_en = 1'b0;
        chk("fill overflow", 32'(overflow), 1);
        chk("fill count held", 32'(count), 64);
        chk("fill full held", 32'(full), 1);

        // drain in order on consecutive cycles
        rd_en = 1'b1;
        for (int k = 0; k < 64; k++) begin
            cyc();
            chk("drain rd_valid", 32'(rd_valid), 1);
            chk("drain rd_data", rd_data, 32'(k));
        end
        rd_en = 1'b0;
        chk("drain empty", 32'(empty), 1);
        chk("drain underflow clear", 32'(underflow), 0);

        // ten more words, then simultaneous requests at count 10
        for (int j = 0; j < 10; j++) begin
            wr_en = 1'b1; wr_data = 32'hA0 + 32'(j);
            cyc();
        end
        chk("sim start count", 32'(count), 10);
        rd_en = 1'b1;
        for (int j = 0; j < 20; j++) begin
            wr_data = 32'hB0 + 32'(j);
            cyc();
            chk("sim count", 32'(count), 10);
            chk("sim rd_valid", 32'(rd_valid), 1);
            chk("sim rd_data", rd_data, j < 10 ? 32'hA0 + 32'(j) : 32'hB0 + 32'(j - 10));
        end
        wr_en = 1'b0;
        for (int j = 10; j < 20; j++) begin
            cyc();
            chk("tail rd_data", rd_data, 32'hB0 + 32'(j));
        end
        chk("tail empty", 32'(empty), 1);
        #1;
        chk("uf ram_re blocked", 32'(ram_re), 0);
        cyc();
        rd_en = 1'b0;
        chk("uf rd_valid", 32'(rd_valid), 0);
        chk("uf underflow", 32'(underflow), 1);

        // full with both requests: only the read goes through
        wr_en = 1'b1;
        for (int j = 0; j < 64; j++) begin
            wr_data = 32'h100 + 32'(j);
            cyc();
        end
        chk("both full", 32'(full), 1);
        rd_en = 1'b1; wr_data = 32'hDEAD;
        #1;
        chk("both full ram_we", 32'(ram_we), 0);
        chk("both full ram_re", 32'(ram_re), 1);
        cyc();
        wr_en = 1'b0;
        chk("both full count", 32'(count), 63);
        chk("both full rd_data", rd_data, 32'h100);
        for (int j = 1; j < 64; j++) cyc();
        chk("both full last", rd_data, 32'h13F);
        chk("both empty", 32'(empty), 1);

        // empty with both requests: only the write goes through
        wr_en = 1'b1; wr_data = 32'h55;
        #1;
        chk("both empty ram_re", 32'(ram_re), 0);
        chk("both empty ram_we", 32'(ram_we), 1);
        cyc();
        wr_en = 1'b0; rd_en = 1'b0;
        chk("both empty count", 32'(count), 1);
        chk("both empty rd_valid", 32'(rd_valid), 0);

        // reset mid-burst with a read accepted
        wr_en = 1'b1; rd_en = 1'b1; wr_data = 32'h77;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_state("mid_rst");
        wr_en = 1'b0; rd_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        chk("post_rst rd_valid", 32'(rd_valid), 0);
        chk("post_rst count", 32'(count), 0);
        wr_en = 1'b1; wr_data = 32'h20;
        cyc();
        wr_en = 1'b0; rd_en = 1'b1;
        cyc();
        rd_en = 1'b0;
        chk("post_rst rd_valid", 32'(rd_valid), 1);
        chk("post_rst rd_data", rd_data, 32'h20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
